ws281x_decoder: RTL and testbench
=================================

// Module: ws281x_decoder
// PURPOSE
// - Receive-side counterpart of the ws281x code generator. Samples one ws281x serial line and measures
//   high/low pulse widths in clk_in cycles, classifies each bit and packs 24-bit pixels (wire order, MSB first).
// - Detects the frame reset gap. Used for loopback checking of cube layer outputs and for chain-tap monitoring.
// PARAMETERS
// - CNT_W  8   width of high-time counter and threshold inputs
// - RST_W  16  width of low-time counter and rst_cnt_in
// - IDX_W  6   width of pixel index within a frame
// PORTS
// - clk_in           in   1      system clock
// - rst_in           in   1      synchronous reset, active-high
// - ws281x_code_in   in   1      asynchronous ws281x data line
// - thr_cnt_in       in   CNT_W  bit-1 threshold: high_cnt > thr -> 1, else 0
// - hmax_cnt_in      in   CNT_W  max legal high time; high_cnt >= hmax -> error
// - rst_cnt_in       in   RST_W  low cycles that mark frame reset
// - pix_valid_out    out  1      pixel available
// - pix_ready_in     in   1      consumer accepts pixel
// - pix_data_out     out  24     decoded pixel, first received bit at [23]
// - pix_idx_out      out  IDX_W  index of pix_data_out within the frame
// - frame_done_out   out  1      1-cycle pulse at reset gap after >=1 pixel
// - err_out          out  1      1-cycle pulse on framing/pulse error
// - ovf_out          out  1      1-cycle pulse when a pixel is dropped
// BEHAVIOUR
// - Reset: all outputs 0, FSM=SYNC, counters/shift register 0, pix index 0.
// - Input path: 2-FF synchroniser then 1 edge register. Rise/fall are detected 3 cycles after the pin change.
// - SYNC: count consecutive low cycles. Any high clears the count. count==rst_cnt_in -> LOW. No bits are decoded.
// - LOW: low_cnt increments, saturating at all-ones.
//   - Rise -> HIGH, high_cnt=1, low_cnt=0.
//   - low_cnt reaches rst_cnt_in -> frame end:
//     - bit_cnt!=0 -> err pulse, partial pixel discarded.
//     - else if >=1 pixel was received in the frame -> frame_done pulse.
//     - In both cases: bit_cnt=0, pix index=0, stay in LOW with no further pulses until the next rise.
// - HIGH: high_cnt increments, saturating at all-ones.
//   - high_cnt>=hmax_cnt_in -> err pulse, bit_cnt=0, go to SYNC.
//   - Fall -> shift in (high_cnt>thr_cnt_in), bit_cnt++, go to LOW.
// - Pixel completion:
//   - On the 24th bit, pix_data/pix_idx load and pix_valid=1 in the next cycle (fall-to-valid latency 1 cycle after edge detect).
//   - Index increments after load and wraps at 2**IDX_W.
// - Handshake: pix_valid holds, data/idx stable, until the cycle with pix_valid&pix_ready, then clears.
//   - Completion in the same cycle as acceptance -> new pixel loads, valid stays 1 (no bubble).
//   - Completion while valid&!ready -> new pixel dropped, ovf pulse, held pixel unchanged, index still increments.
// - Simultaneous err and frame end: err wins, no frame_done.
// - rst_in mid-frame: immediate return to reset state. The decoder re-syncs via SYNC and drops the partial frame.
// - thr/hmax/rst inputs are sampled live and must be static during a frame.
// CONFIGURATION
// - WS281X_DEC_ERR_CNT_EN defined:
//   - Adds output err_cnt_out [15:0], a saturating count of err pulses plus ovf pulses.
//   - Cleared only by rst_in.
// - Not defined: port absent, no counter logic. All other behaviour identical.
// TESTING
// - thr=40, hmax=100, rst=400. Idle low 400 cycles, then 24 bits 0xA5C3F0 (1=64H/36L, 0=32H/68L), then low 400
//   -> pix_data=0xA5C3F0, idx=0, frame_done pulse once.
// - 3 pixels, pix_ready held 0 -> first pixel held, ovf pulses 2x, idx output stays 0.
//   - Then ready=1 -> valid drops next cycle.
// - 10 bits then low 400 -> err pulse, no pix_valid, no frame_done.
//   - Next full pixel -> idx=0.
// - High for 100 cycles mid-pixel -> err pulse, FSM SYNC.
//   - Bits ignored until 400 low cycles have elapsed, then the next pixel decodes correctly.
// - High exactly 40 -> bit 0; high 41 -> bit 1. Assert rst_in during bit 12 -> all outputs 0 next cycle, decoder re-syncs.
// - With WS281X_DEC_ERR_CNT_EN: 2 errors + 1 overflow -> err_cnt_out=3. Without the macro: build has no err_cnt_out.

Source files
------------

// File: rtl/ws281x_decoder_if.sv
// Pixel output channel of the ws281x decoder.
`timescale 1ns / 1ps
interface ws281x_decoder_if #(
  parameter int IDX_W = 6
) ();
  // Valid/ready: the producer raises pix_valid_out and holds it, with pix_data_out and
  // pix_idx_out stable, until a rising clk_in edge samples pix_valid_out & pix_ready_in.
  // pix_valid_out never depends combinationally on pix_ready_in.
  logic              pix_valid_out;
  logic              pix_ready_in;
  logic [23:0]       pix_data_out;
  logic [IDX_W-1:0]  pix_idx_out;

  modport master (output pix_valid_out, output pix_data_out, output pix_idx_out, input pix_ready_in);
  modport slave  (input pix_valid_out, input pix_data_out, input pix_idx_out, output pix_ready_in);
endinterface

// File: rtl/ws281x_decoder.sv
// ws281x line receiver: measures pulse widths, packs 24-bit pixels, flags frame gaps and errors.
// Optional WS281X_DEC_ERR_CNT_EN adds err_cnt_out, a saturating count of err and ovf pulses.
`timescale 1ns / 1ps
module ws281x_decoder #(
  parameter int CNT_W = 8,
  parameter int RST_W = 16,
  parameter int IDX_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ws281x_code_in,
  input  logic [CNT_W-1:0] thr_cnt_in,
  input  logic [CNT_W-1:0] hmax_cnt_in,
  input  logic [RST_W-1:0] rst_cnt_in,
  ws281x_decoder_if.master pix_if,
  output logic             frame_done_out,
  output logic             err_out,
  output logic             ovf_out,
  output logic [1:0]       state_dbg_out
`ifdef WS281X_DEC_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt_out
`endif
);

  typedef enum logic [1:0] {ST_SYNC = 2'd0, ST_LOW = 2'd1, ST_HIGH = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
  logic [RST_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pix_seen_q, pix_seen_d;
  logic             gap_q, gap_d;
  logic             pix_valid_q, pix_valid_d;
  logic [23:0]      pix_data_q, pix_data_d;
  logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic             level, rise, fall;
  logic [RST_W-1:0] low_inc;
  logic [CNT_W-1:0] high_inc;
  logic [23:0]      new_shift;

  assign level     = sync2_q;
  assign rise      = sync2_q & ~edge_q;
  assign fall      = ~sync2_q & edge_q;
  assign low_inc   = (&low_cnt_q) ? low_cnt_q : low_cnt_q + RST_W'(1);
  assign high_inc  = (&high_cnt_q) ? high_cnt_q : high_cnt_q + CNT_W'(1);
  assign new_shift = {shift_q[22:0], (high_cnt_q > thr_cnt_in)};

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: if (!level && (low_cnt_q == rst_cnt_in)) state_d = ST_LOW;
      ST_LOW:  if (rise) state_d = ST_HIGH;
      ST_HIGH: begin
        if (high_cnt_q >= hmax_cnt_in) state_d = ST_SYNC;
        else if (fall)                 state_d = ST_LOW;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    sync1_d      = ws281x_code_in;
    sync2_d      = sync1_q;
    edge_d       = sync2_q;
    low_cnt_d    = low_cnt_q;
    high_cnt_d   = high_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    pix_seen_d   = pix_seen_q;
    gap_d        = gap_q;
    pix_valid_d  = pix_valid_q & ~pix_if.pix_ready_in;
    pix_data_d   = pix_data_q;
    pix_idx_d    = pix_idx_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    ovf_d        = 1'b0;
    case (state_q)
      ST_SYNC: begin
        // No frame is in progress while hunting for the gap; gap_q stays set so LOW starts quiet.
        low_cnt_d  = level ? '0 : low_inc;
        bit_cnt_d  = '0;
        idx_d      = '0;
        pix_seen_d = 1'b0;
        gap_d      = 1'b1;
      end
      ST_LOW: begin
        if (rise) begin
          high_cnt_d = CNT_W'(1);
          low_cnt_d  = '0;
          gap_d      = 1'b0;
        end else begin
          low_cnt_d = low_inc;
          if (!gap_q && (low_cnt_q == rst_cnt_in)) begin
            gap_d      = 1'b1;
            bit_cnt_d  = '0;
            idx_d      = '0;
            pix_seen_d = 1'b0;
            if (bit_cnt_q != 5'd0) err_d = 1'b1;
            else if (pix_seen_q)   frame_done_d = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (high_cnt_q >= hmax_cnt_in) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          low_cnt_d = '0;
        end else if (fall) begin
          shift_d   = new_shift;
          low_cnt_d = RST_W'(1);
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d  = '0;
            pix_seen_d = 1'b1;
            idx_d      = idx_q + IDX_W'(1);
            // A free slot or a same-cycle acceptance takes the new pixel; otherwise it is lost.
            if (!pix_valid_q || pix_if.pix_ready_in) begin
              pix_valid_d = 1'b1;
              pix_data_d  = new_shift;
              pix_idx_d   = idx_q;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          high_cnt_d = high_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      edge_q       <= 1'b0;
      low_cnt_q    <= '0;
      high_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      pix_seen_q   <= 1'b0;
      gap_q        <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_idx_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      edge_q       <= edge_d;
      low_cnt_q    <= low_cnt_d;
      high_cnt_q   <= high_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      pix_seen_q   <= pix_seen_d;
      gap_q        <= gap_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_idx_q    <= pix_idx_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign pix_if.pix_valid_out = pix_valid_q;
  assign pix_if.pix_data_out  = pix_data_q;
  assign pix_if.pix_idx_out   = pix_idx_q;
  assign frame_done_out       = frame_done_q;
  assign err_out              = err_q;
  assign ovf_out              = ovf_q;
  assign state_dbg_out        = state_q;

`ifdef WS281X_DEC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((err_q || ovf_q) && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_out = err_cnt_q;
`endif

endmodule

// File: tb/tb_ws281x_decoder.sv
// Directed bench for ws281x_decoder: pixel decode, backpressure, framing errors, thresholds, reset.
`timescale 1ns / 1ps
module tb_ws281x_decoder;

  localparam int IDX_W = 6;
  localparam int W     = IDX_W + 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        code = 1'b0;
  logic [7:0]  thr = 8'd40;
  logic [7:0]  hmax = 8'd100;
  logic [15:0] rst_cnt = 16'd400;
  logic        frame_done, err, ovf;
  logic [1:0]  state_dbg;
`ifdef WS281X_DEC_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  ws281x_decoder_if #(.IDX_W(IDX_W)) pix_if ();

  ws281x_decoder dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .ws281x_code_in (code),
    .thr_cnt_in     (thr),
    .hmax_cnt_in    (hmax),
    .rst_cnt_in     (rst_cnt),
    .pix_if         (pix_if),
    .frame_done_out (frame_done),
    .err_out        (err),
    .ovf_out        (ovf),
    .state_dbg_out  (state_dbg)
`ifdef WS281X_DEC_ERR_CNT_EN
    ,
    .err_cnt_out    (err_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int fd_n = 0, err_n = 0, ovf_n = 0, acc_n = 0, vld_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard / pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_done) fd_n++;
    if (err) err_n++;
    if (ovf) ovf_n++;
    if (pix_if.pix_valid_out) vld_n++;
    if (pix_if.pix_valid_out && pix_if.pix_ready_in) begin
      acc_n++;
      if (exp_q.size() == 0) check("unexpected_pixel", 32'(pix_if.pix_data_out), 32'hFFFF_FFFF);
      else check("pixel", 32'({pix_if.pix_idx_out, pix_if.pix_data_out}), 32'(exp_q.pop_front()));
    end
  end

  // drivers
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    code = 1'b1;
    wait_cyc(b ? 64 : 32);
    code = 1'b0;
    wait_cyc(b ? 36 : 68);
  endtask

  task automatic send_bits(input logic [23:0] d, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(d[i]);
  endtask

  int fd0, err0, ovf0, acc0, vld0;
  task automatic snap();
    fd0 = fd_n; err0 = err_n; ovf0 = ovf_n; acc0 = acc_n; vld0 = vld_n;
  endtask

  initial begin
    pix_if.pix_ready_in = 1'b0;
    wait_cyc(3);
    check("rst_valid", 32'(pix_if.pix_valid_out), 32'd0);
    check("rst_data", 32'(pix_if.pix_data_out), 32'd0);
    check("rst_idx", 32'(pix_if.pix_idx_out), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
`ifdef WS281X_DEC_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;

    // single pixel frame
    pix_if.pix_ready_in = 1'b1;
    wait_cyc(420);
    check("sync_to_low", 32'(state_dbg), 32'd1);
    snap();
    exp_q.push_back({6'd0, 24'hA5C3F0});
    send_bits(24'hA5C3F0, 24);
    wait_cyc(420);
    check("p1_accepted", 32'(acc_n - acc0), 32'd1);
    check("p1_frame_done", 32'(fd_n - fd0), 32'd1);
    check("p1_no_err", 32'(err_n - err0), 32'd0);

    // three pixels against a stalled consumer
    pix_if.pix_ready_in = 1'b0;
    snap();
    exp_q.push_back({6'd0, 24'h123456});
    send_bits(24'h123456, 24);
    send_bits(24'hFEDCBA, 24);
    send_bits(24'h0F0F0F, 24);
    check("stall_ovf", 32'(ovf_n - ovf0), 32'd2);
    check("stall_valid", 32'(pix_if.pix_valid_out), 32'd1);
    check("stall_data", 32'(pix_if.pix_data_out), 32'h123456);
    check("stall_idx", 32'(pix_if.pix_idx_out), 32'd0);
    pix_if.pix_ready_in = 1'b1;
    wait_cyc(1);
    check("valid_drop", 32'(pix_if.pix_valid_out), 32'd0);
    wait_cyc(420);
    check("stall_frame_done", 32'(fd_n - fd0), 32'd1);

    // partial pixel then gap
    snap();
    send_bits(24'hC3A500, 10);
    wait_cyc(420);
    check("partial_err", 32'(err_n - err0), 32'd1);
    check("partial_no_valid", 32'(vld_n - vld0), 32'd0);
    check("partial_no_fd", 32'(fd_n - fd0), 32'd0);
    exp_q.push_back({6'd0, 24'h5A5A5A});
    send_bits(24'h5A5A5A, 24);
    wait_cyc(420);
    check("after_partial_fd", 32'(fd_n - fd0), 32'd1);

    // over-long high pulse mid-pixel
    snap();
    send_bits(24'hFFFFFF, 5);
    code = 1'b1;
    wait_cyc(100);
    code = 1'b0;
    wait_cyc(6);
    check("hmax_err", 32'(err_n - err0), 32'd1);
    check("hmax_state_sync", 32'(state_dbg), 32'd0);
    send_bits(24'hFFFFFF, 3);
    wait_cyc(420);
    check("sync_ignored_bits", 32'(vld_n - vld0), 32'd0);
    check("resync_low", 32'(state_dbg), 32'd1);
    exp_q.push_back({6'd0, 24'h3C96E1});
    send_bits(24'h3C96E1, 24);
    wait_cyc(420);
    check("hmax_total_err", 32'(err_n - err0), 32'd1);
    check("hmax_fd", 32'(fd_n - fd0), 32'd1);
`ifdef WS281X_DEC_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'd4);
`endif

    // threshold boundary: 41 high -> 1, 40 high -> 0
    exp_q.push_back({6'd0, 24'hAAAAAA});
    for (int i = 0; i < 24; i++) begin
      code = 1'b1;
      wait_cyc((i % 2 == 0) ? 41 : 40);
      code = 1'b0;
      wait_cyc(60);
    end
    wait_cyc(420);

    // reset during bit 12 with a pixel held
    pix_if.pix_ready_in = 1'b0;
    send_bits(24'h87654F, 24);
    check("held_before_rst", 32'(pix_if.pix_valid_out), 32'd1);
    send_bits(24'hFFFFFF, 11);
    code = 1'b1;
    wait_cyc(20);
    rst = 1'b1;
    wait_cyc(1);
    check("mid_rst_valid", 32'(pix_if.pix_valid_out), 32'd0);
    check("mid_rst_data", 32'(pix_if.pix_data_out), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
`ifdef WS281X_DEC_ERR_CNT_EN
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;
    wait_cyc(30);
    code = 1'b0;
    pix_if.pix_ready_in = 1'b1;
    snap();
    wait_cyc(420);
    exp_q.push_back({6'd0, 24'h0055FF});
    send_bits(24'h0055FF, 24);
    wait_cyc(420);
    check("post_rst_accept", 32'(acc_n - acc0), 32'd1);
    check("post_rst_fd", 32'(fd_n - fd0), 32'd1);
    check("post_rst_no_err", 32'(err_n - err0), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
